nibble_fetch: RTL and testbench

- Instruction fetch/decode stage that sits directly upstream of the nibble control unit.
- Holds the program counter and issues read requests to program memory over a req/ack handshake.
- Latches the 8-bit instruction word and splits it into the 3-bit opcode and 4-bit immediate consumed downstream.
- Presents decoded instructions on a valid/ready handshake; supports redirect (branch) from execute.

---
 rtl/nibble_pkg.sv | 31 +++
 rtl/nibble_pc.sv | 34 +++
 rtl/nibble_fetch.sv | 146 ++++++++++++++
 tb/tb_nibble_fetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared constants, field positions and fetch state type
// Purpose: instruction word layout and fetch FSM encoding used by the fetch stage.
// Ports: none (package).
package nibble_pkg;

  localparam int OP_W    = 3;
  localparam int IMM_W   = 4;
  localparam int INSTR_W = 8;

  // Instruction word layout: [7:5] opcode, [4] reserved, [3:0] immediate
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 5;
  localparam int RSVD_BIT = 4;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [IMM_W-1:0] instr_imm(input logic [INSTR_W-1:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/nibble_pc.sv
// rtl/nibble_pc.sv - program counter register with load and wrapping increment
// Purpose: holds the fetch address; load (redirect) has priority over increment.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-low reset, loads RESET_PC
//   load     - load load_val this cycle
//   load_val - redirect address
//   inc      - increment by one, wrapping modulo 2^PC_W
//   pc       - current program counter
module nibble_pc
  import nibble_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= PC_W'(RESET_PC);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/nibble_fetch.sv
// rtl/nibble_fetch.sv - instruction fetch/decode stage with redirect support
// Purpose: fetches 8-bit instruction words over a req/ack memory handshake,
// holds the decoded opcode/immediate on a valid/ready handshake, and accepts
// one-cycle branch redirects from execute.
// Optional: define NIBBLE_FETCH_PERF_EN to add the instr_count output.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   mem_addr, mem_req    - program memory read request (address = pc)
//   mem_ack, mem_rdata   - read completion and instruction word
//   op, imm, instr_valid - decoded instruction presented downstream
//   instr_ready          - downstream accepts the instruction
//   branch_en/target     - redirect request and address
//   pc_out               - address of the instruction held in IR
//   instr_count          - (perf build only) saturating accepted-instruction count
module nibble_fetch
  import nibble_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    mem_addr,
  output logic               mem_req,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [OP_W-1:0]    op,
  output logic [IMM_W-1:0]   imm,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc_out
`ifdef NIBBLE_FETCH_PERF_EN
  ,
  output logic [15:0]        instr_count
`endif
);

  fetch_state_e       state, state_nxt;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               branch_pend, pend_nxt;
  logic               load_pc, inc_pc, capture;
  logic               ir_unused;

  nibble_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (load_pc),
    .load_val (branch_target),
    .inc      (inc_pc),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A redirect during an outstanding read cannot abort it, so the read is
  // completed and its data dropped (branch_pend) before refetching at pc.
  always_comb begin
    state_nxt = state;
    pend_nxt  = branch_pend;
    load_pc   = 1'b0;
    inc_pc    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt = FETCH;
        load_pc   = branch_en;
      end
      FETCH: begin
        if (branch_en) begin
          load_pc  = 1'b1;
          pend_nxt = !mem_ack;
        end else if (mem_ack) begin
          if (branch_pend) begin
            pend_nxt = 1'b0;
          end else begin
            capture   = 1'b1;
            inc_pc    = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        // Branch wins over a simultaneous accept; the held instruction is dropped.
        if (branch_en) begin
          load_pc   = 1'b1;
          state_nxt = FETCH;
        end else if (instr_ready) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      FETCH:   mem_req     = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir          <= '0;
      pc_out      <= PC_W'(RESET_PC);
      branch_pend <= 1'b0;
    end else begin
      branch_pend <= pend_nxt;
      if (capture) begin
        ir     <= mem_rdata;
        pc_out <= pc;
      end
    end
  end

  assign mem_addr  = pc;
  assign op        = instr_op(ir);
  assign imm       = instr_imm(ir);
  assign ir_unused = ir[RSVD_BIT];

`ifdef NIBBLE_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (state == HOLD && instr_ready && !branch_en && instr_count != 16'hFFFF) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_fetch.sv
// tb/tb_nibble_fetch.sv - self-checking bench for nibble_fetch
module tb_nibble_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [2:0] op;
  logic [3:0] imm;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       branch_en = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic [7:0] pc_out;
`ifdef NIBBLE_FETCH_PERF_EN
  logic [15:0] instr_count;
`endif

  int passed = 0;
  int total  = 0;

  nibble_fetch #(.PC_W(8), .RESET_PC(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .op            (op),
    .imm           (imm),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .pc_out        (pc_out)
`ifdef NIBBLE_FETCH_PERF_EN
    ,
    .instr_count   (instr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Program memory and responder: fixed_wait >= 0 gives that many wait cycles,
  // negative picks 0..3 per request. Non-ack cycles drive garbage read data.
  logic [7:0] mem [0:255];
  int  fixed_wait = 0;
  int  cur_wait = 0;
  int  wcnt = 0;
  bit  started = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!reset || !mem_req) begin
      mem_ack   = 1'b0;
      started   = 1'b0;
      mem_rdata = 8'($urandom);
    end else begin
      if (!started) begin
        started  = 1'b1;
        wcnt     = 0;
        cur_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
      if (wcnt == cur_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        started   = 1'b0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wcnt++;
      end
    end
  end

  // Reference model at instruction-stream level: the next presented instruction
  // comes from the most recent redirect target, otherwise from the address after
  // the last consumed instruction; a presentation stays frozen until consumed.
  logic [7:0] exp_addr = 8'h00;
  logic [7:0] cur_addr = 8'h00;
  logic [7:0] word;
  logic       prev_valid = 0, prev_ready = 0, prev_branch = 0, prev_req = 0, prev_ack = 0;
  logic [14:0] prev_out = '0;
  int n_pres = 0;
  int cons_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_addr    = 8'h00;
      prev_valid  = 0;
      prev_ready  = 0;
      prev_branch = 0;
      prev_req    = 0;
      prev_ack    = 0;
      cons_cnt    = 0;
    end else begin
      if (prev_branch) begin
        chk("valid_drop_after_branch", instr_valid, 0);
      end else if (prev_valid && !prev_ready) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_stable", {op, imm, pc_out}, prev_out);
      end
      if (prev_req && !prev_ack) chk("req_held", mem_req, 1);
      chk("req_while_valid", mem_req & instr_valid, 0);
      if (instr_valid && !prev_valid) begin
        n_pres++;
        word = mem[exp_addr];
        chk("present_pc", pc_out, exp_addr);
        chk("present_instr", {op, imm}, {word[7:5], word[3:0]});
        cur_addr = exp_addr;
      end
      if (branch_en) exp_addr = branch_target;
      else if (instr_valid && instr_ready) exp_addr = cur_addr + 8'd1;
      if (instr_valid && instr_ready && !branch_en) cons_cnt++;
      prev_valid  = instr_valid;
      prev_ready  = instr_ready;
      prev_branch = branch_en;
      prev_req    = mem_req;
      prev_ack    = mem_ack;
      prev_out    = {op, imm, pc_out};
    end
  end

  typedef struct {
    logic       rdy;
    logic       br;
    logic [7:0] tgt;
    logic       exp_valid;
    logic       exp_req;
    logic [7:0] exp_addr;
    logic [7:0] exp_pc;
    logic [2:0] exp_op;
    logic [3:0] exp_imm;
  } vec_t;

  initial begin
    vec_t vt [11];
    int   n;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hA5;
    mem[8'h01] = 8'h3C;
    mem[8'h07] = 8'h11;
    mem[8'h10] = 8'hC9;
    mem[8'h40] = 8'hE2;
    mem[8'hFF] = 8'h5F;

    // Inputs applied for one clock edge, outputs expected after that edge.
    vt[0]  = '{0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 3'd0, 4'h0};
    vt[1]  = '{0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 3'd5, 4'h5};
    vt[2]  = '{0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 3'd5, 4'h5};
    vt[3]  = '{1, 0, 8'h00, 0, 1, 8'h01, 8'h00, 3'd0, 4'h0};
    vt[4]  = '{1, 0, 8'h00, 1, 0, 8'h00, 8'h01, 3'd1, 4'hC};
    vt[5]  = '{1, 1, 8'h40, 0, 1, 8'h40, 8'h00, 3'd0, 4'h0};
    vt[6]  = '{0, 0, 8'h00, 1, 0, 8'h00, 8'h40, 3'd7, 4'h2};
    vt[7]  = '{0, 1, 8'hFF, 0, 1, 8'hFF, 8'h00, 3'd0, 4'h0};
    vt[8]  = '{1, 0, 8'h00, 1, 0, 8'h00, 8'hFF, 3'd2, 4'hF};
    vt[9]  = '{1, 0, 8'h00, 0, 1, 8'h00, 8'h00, 3'd0, 4'h0};
    vt[10] = '{0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 3'd5, 4'h5};

    #3;
    chk("reset_req", mem_req, 0);
    chk("reset_valid", instr_valid, 0);
    chk("reset_op_imm", {op, imm}, 0);
    chk("reset_pc_out", pc_out, 0);
    chk("reset_addr", mem_addr, 0);

    @(posedge clk); #2;
    reset = 1'b1;
    fixed_wait = 0;

    for (int i = 0; i < 11; i++) begin
      instr_ready   = vt[i].rdy;
      branch_en     = vt[i].br;
      branch_target = vt[i].tgt;
      @(posedge clk); #2;
      chk($sformatf("vec%0d_valid", i), instr_valid, vt[i].exp_valid);
      chk($sformatf("vec%0d_req", i), mem_req, vt[i].exp_req);
      if (vt[i].exp_req) chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].exp_addr);
      if (vt[i].exp_valid) begin
        chk($sformatf("vec%0d_pc_out", i), pc_out, vt[i].exp_pc);
        chk($sformatf("vec%0d_op_imm", i), {op, imm}, {vt[i].exp_op, vt[i].exp_imm});
      end
    end
    instr_ready = 1'b0;
    branch_en   = 1'b0;

    // Backpressure: five stalled cycles, then resume.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("bp_valid", instr_valid, 1);
      chk("bp_req", mem_req, 0);
      chk("bp_op_imm", {op, imm}, {3'd5, 4'h5});
    end
    fixed_wait  = 3;
    instr_ready = 1'b1;
    @(posedge clk); #2;
    instr_ready = 1'b0;
    chk("bp_resume_req", mem_req, 1);
    chk("bp_resume_addr", mem_addr, 8'h01);

    // Three wait states: request held four cycles, IR untouched until ack.
    n = 1;
    for (int i = 0; i < 20 && !instr_valid; i++) begin
      chk("wait_ir_stable", {op, imm}, {3'd5, 4'h5});
      @(posedge clk); #2;
      if (mem_req) begin
        n++;
        chk("wait_addr_stable", mem_addr, 8'h01);
      end
    end
    chk("wait_req_cycles", n, 4);
    chk("wait_valid", instr_valid, 1);
    chk("wait_pc_out", pc_out, 8'h01);
    chk("wait_op_imm", {op, imm}, {3'd1, 4'hC});

    // Redirect during a two-wait fetch of 0x07.
    fixed_wait    = 2;
    branch_en     = 1'b1;
    branch_target = 8'h07;
    @(posedge clk); #2;
    chk("pend_fetch07", mem_addr, 8'h07);
    branch_target = 8'h10;
    @(posedge clk); #2;
    branch_en = 1'b0;
    chk("pend_req", mem_req, 1);
    chk("pend_addr", mem_addr, 8'h10);
    n = 1;
    for (int i = 0; i < 20 && !instr_valid; i++) begin
      @(posedge clk); #2;
      n++;
    end
    chk("pend_cycles", n, 6);
    chk("pend_valid", instr_valid, 1);
    chk("pend_pc_out", pc_out, 8'h10);
    chk("pend_op_imm", {op, imm}, {3'd6, 4'h9});

    // Asynchronous reset in the middle of a wait state.
    fixed_wait  = 3;
    instr_ready = 1'b1;
    @(posedge clk); #2;
    instr_ready = 1'b0;
    chk("rst_pre_addr", mem_addr, 8'h11);
    @(posedge clk); #2;
    chk("rst_pre_req", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("rst_async_req", mem_req, 0);
    chk("rst_async_valid", instr_valid, 0);
    chk("rst_async_addr", mem_addr, 0);
    chk("rst_async_pc_out", pc_out, 0);
    fixed_wait = 0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    chk("rst_restart_req", mem_req, 1);
    chk("rst_restart_addr", mem_addr, 8'h00);
    @(posedge clk); #2;
    chk("rst_restart_valid", instr_valid, 1);
    chk("rst_restart_op_imm", {op, imm, pc_out}, {3'd5, 4'h5, 8'h00});

    // Random traffic against the stream-level model.
    fixed_wait = -1;
    n_pres = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready   = ($urandom_range(0, 9) < 7);
      branch_en     = ($urandom_range(0, 15) == 0);
      branch_target = 8'($urandom);
      @(posedge clk); #2;
    end
    instr_ready = 1'b0;
    branch_en   = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("random_progress", (n_pres > 100) ? 1 : 0, 1);
`ifdef NIBBLE_FETCH_PERF_EN
    chk("perf_count", instr_count, cons_cnt);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
